// File: rtl/debug_trace_serializer_pkg.sv
// -----------------------------------------------------------------------------
// debug_trace_serializer_pkg
// Shared types for the commit-trace serializer:
//   debug_bus_t  - one committed instruction as seen on a commit debug bus
//   trace_rec_t  - one queued trace record {pc, wen, wnum, wdata}
//   to_trace_rec - builds a trace record from a commit bus; a write to r0 is
//                  not a real register write, so its strobe is cleared
// -----------------------------------------------------------------------------
package debug_trace_serializer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  wstrb;
        logic [4:0]  dest;
        logic [5:0]  phy_dest;
        logic [31:0] wdata;
        logic [2:0]  br_op;
        logic        predict_sucess;
    } debug_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_rec_t;

    function automatic trace_rec_t to_trace_rec(input debug_bus_t b);
        trace_rec_t r;
        r.pc    = b.pc;
        r.wen   = (b.dest == '0) ? '0 : b.wstrb;
        r.wnum  = b.dest;
        r.wdata = b.wdata;
        return r;
    endfunction

endpackage

// File: rtl/debug_trace_serializer_if.sv
// -----------------------------------------------------------------------------
// Interfaces for the commit-trace serializer.
//
// trace_fifo_if : internal push/pop bundle between the serializer and its FIFO
//   push0/data0 : first record of this cycle (always the older one)
//   push1/data1 : second record of this cycle (only asserted with push0)
//   pop         : remove the head entry
//   head/count  : head entry and registered occupancy
//   modports    : master (serializer side), slave (FIFO side)
//
// debug_trace_serializer_if : bundle of everything around the serializer
//   (both commit buses, consumer ready, the trace outputs, status, counters)
//   modports    : master (commit/consumer side), slave (serializer side)
// -----------------------------------------------------------------------------
interface trace_fifo_if #(
    parameter int unsigned DEPTH = 8
) ();
    import debug_trace_serializer_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push0;
    logic          push1;
    trace_rec_t    data0;
    trace_rec_t    data1;
    logic          pop;
    trace_rec_t    head;
    logic [CW-1:0] count;

    modport master (output push0, push1, data0, data1, pop, input head, count);
    modport slave  (input push0, push1, data0, data1, pop, output head, count);
endinterface

interface debug_trace_serializer_if;
    import debug_trace_serializer_pkg::*;

    debug_bus_t  bus1;
    debug_bus_t  bus2;
    logic        out_ready;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [3:0]  wb_wen;
    logic [4:0]  wb_wnum;
    logic [31:0] wb_wdata;
    logic        stall_req;
    logic        overflow;
    logic [31:0] inst_cnt;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    modport master (output bus1, bus2, out_ready,
                    input  wb_valid, wb_pc, wb_wen, wb_wnum, wb_wdata,
                           stall_req, overflow, inst_cnt, br_cnt, mispred_cnt);
    modport slave  (input  bus1, bus2, out_ready,
                    output wb_valid, wb_pc, wb_wen, wb_wnum, wb_wdata,
                           stall_req, overflow, inst_cnt, br_cnt, mispred_cnt);
endinterface

// File: rtl/debug_trace_serializer_trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Two-write, one-read synchronous FIFO of trace_rec_t.
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset of pointers and count
//   fif   : trace_fifo_if.slave (push0/push1/data0/data1/pop in,
//           head/count out)
// The caller guarantees push1 only with push0 and never exceeds capacity.
// Storage is not reset; head is only meaningful while count != 0.
// -----------------------------------------------------------------------------
module trace_fifo
    import debug_trace_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    trace_fifo_if.slave fif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    trace_rec_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(fif.push0) + PW'(fif.push1);
        rd_ptr_d = rd_ptr_q + PW'(fif.pop);
        count_d  = count_q + CW'(fif.push0) + CW'(fif.push1) - CW'(fif.pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fif.push0) mem_q[wr_ptr_q] <= fif.data0;
        if (fif.push1) mem_q[wr_ptr_q + PW'(1)] <= fif.data1;
    end

    assign fif.head  = mem_q[rd_ptr_q];
    assign fif.count = count_q;

endmodule

// File: rtl/debug_trace_serializer.sv
// -----------------------------------------------------------------------------
// debug_trace_serializer
// Turns up to two committed instructions per cycle into a one-per-cycle
// register-writeback trace stream, with commit performance counters.
//   clk, reset          : clock; asynchronous active-high reset
//   debug_bus1/2        : older/younger committed instruction this cycle
//   out_ready           : consumer takes the presented head record
//   debug_wb_*          : head record (all zero while the queue is empty)
//   stall_req           : fewer than two free entries remain
//   overflow            : sticky, a record was lost for lack of space
//   inst_cnt/br_cnt/mispred_cnt : free-running commit counters (wrap 2^32)
// -----------------------------------------------------------------------------
module debug_trace_serializer
    import debug_trace_serializer_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter bit          DROP_NO_WRITE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  debug_bus_t  debug_bus1,
    input  debug_bus_t  debug_bus2,
    input  logic        out_ready,
    output logic        debug_wb_valid,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        stall_req,
    output logic        overflow,
    output logic [31:0] inst_cnt,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    trace_fifo_if #(.DEPTH(DEPTH)) fif ();

    trace_fifo #(.DEPTH(DEPTH)) u_trace_fifo (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    trace_rec_t    rec1, rec2, head;
    logic          want1, want2;
    logic          pop, push0, push1, lost;
    logic [CW-1:0] count, cap;
    logic          overflow_q, overflow_d;
    logic [31:0]   inst_cnt_q, inst_cnt_d;
    logic [31:0]   br_cnt_q, br_cnt_d;
    logic [31:0]   mispred_cnt_q, mispred_cnt_d;
    logic          unused_bits;

    assign count = fif.count;

    // Candidates are placed in commit order into slot0/slot1; space runs out
    // from the back, so the younger record is the one dropped first.
    always_comb begin
        rec1  = to_trace_rec(debug_bus1);
        rec2  = to_trace_rec(debug_bus2);
        want1 = debug_bus1.valid && (!DROP_NO_WRITE || (rec1.wen != '0));
        want2 = debug_bus2.valid && (!DROP_NO_WRITE || (rec2.wen != '0));
        pop   = (count != '0) && out_ready;
        cap   = DEPTH_C - count + CW'(pop);
        push0 = (want1 || want2) && (cap >= CW'(1));
        push1 = want1 && want2 && (cap >= CW'(2));
        lost  = ((want1 || want2) && !push0) || (want1 && want2 && !push1);

        overflow_d = overflow_q | lost;

        inst_cnt_d = inst_cnt_q + 32'(debug_bus1.valid) + 32'(debug_bus2.valid);
        br_cnt_d   = br_cnt_q
                   + 32'(debug_bus1.valid && (debug_bus1.br_op != '0))
                   + 32'(debug_bus2.valid && (debug_bus2.br_op != '0));
        mispred_cnt_d = mispred_cnt_q
                   + 32'(debug_bus1.valid && (debug_bus1.br_op != '0) && !debug_bus1.predict_sucess)
                   + 32'(debug_bus2.valid && (debug_bus2.br_op != '0) && !debug_bus2.predict_sucess);
    end

    assign fif.push0 = push0;
    assign fif.push1 = push1;
    assign fif.data0 = want1 ? rec1 : rec2;
    assign fif.data1 = rec2;
    assign fif.pop   = pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q    <= 1'b0;
            inst_cnt_q    <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            overflow_q    <= overflow_d;
            inst_cnt_q    <= inst_cnt_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Storage is not reset, so the head is masked while the queue is empty.
    assign debug_wb_valid    = (count != '0);
    assign head              = debug_wb_valid ? fif.head : '0;
    assign debug_wb_pc       = head.pc;
    assign debug_wb_rf_wen   = head.wen;
    assign debug_wb_rf_wnum  = head.wnum;
    assign debug_wb_rf_wdata = head.wdata;

    assign stall_req   = ((DEPTH_C - count) < CW'(2));
    assign overflow    = overflow_q;
    assign inst_cnt    = inst_cnt_q;
    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    assign unused_bits = ^{debug_bus1.phy_dest, debug_bus2.phy_dest};

endmodule

// File: tb/tb_debug_trace_serializer.sv
// -----------------------------------------------------------------------------
// tb_debug_trace_serializer
// Directed bench for debug_trace_serializer (DEPTH=8, DROP_NO_WRITE=1).
// -----------------------------------------------------------------------------
module tb_debug_trace_serializer;
    import debug_trace_serializer_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    debug_trace_serializer_if dif ();

    debug_trace_serializer #(
        .DEPTH         (8),
        .DROP_NO_WRITE (1'b1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .debug_bus1        (dif.bus1),
        .debug_bus2        (dif.bus2),
        .out_ready         (dif.out_ready),
        .debug_wb_valid    (dif.wb_valid),
        .debug_wb_pc       (dif.wb_pc),
        .debug_wb_rf_wen   (dif.wb_wen),
        .debug_wb_rf_wnum  (dif.wb_wnum),
        .debug_wb_rf_wdata (dif.wb_wdata),
        .stall_req         (dif.stall_req),
        .overflow          (dif.overflow),
        .inst_cnt          (dif.inst_cnt),
        .br_cnt            (dif.br_cnt),
        .mispred_cnt       (dif.mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic debug_bus_t mk(input logic v, input logic [31:0] pc, input logic [3:0] ws,
                                      input logic [4:0] dest, input logic [31:0] wd,
                                      input logic [2:0] br, input logic pred);
        debug_bus_t b;
        b = '0;
        b.valid = v; b.pc = pc; b.wstrb = ws; b.dest = dest; b.wdata = wd;
        b.br_op = br; b.predict_sucess = pred;
        return b;
    endfunction

    // Numbered test record with a real register write.
    function automatic debug_bus_t rec(input int id);
        return mk(1'b1, 32'h1000 + 32'(id) * 4, 4'hF, 5'(id % 31 + 1), 32'hA500_0000 + 32'(id), 3'd0, 1'b1);
    endfunction

    task automatic idle();
        dif.bus1 = '0;
        dif.bus2 = '0;
    endtask

    task automatic expect_head(input string tag, input int id);
        check_eq({tag, ".valid"}, 64'(dif.wb_valid), 64'd1);
        check_eq({tag, ".pc"}, 64'(dif.wb_pc), 64'(32'h1000 + 32'(id) * 4));
        check_eq({tag, ".wnum"}, 64'(dif.wb_wnum), 64'(id % 31 + 1));
    endtask

    // Fill to count=7 with three dual pushes (ids 0..5) and one single (id 6).
    task automatic fill_to_seven();
        for (int i = 0; i < 3; i++) begin
            dif.bus1 = rec(2 * i);
            dif.bus2 = rec(2 * i + 1);
            tick();
        end
        idle();
        check_eq("fill6.stall", 64'(dif.stall_req), 64'd0);
        dif.bus1 = rec(6);
        tick();
        idle();
        check_eq("fill7.stall", 64'(dif.stall_req), 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        dif.out_ready = 1'b0;
        repeat (3) tick();

        check_eq("rst.valid", 64'(dif.wb_valid), 64'd0);
        check_eq("rst.pc", 64'(dif.wb_pc), 64'd0);
        check_eq("rst.wen", 64'(dif.wb_wen), 64'd0);
        check_eq("rst.overflow", 64'(dif.overflow), 64'd0);
        check_eq("rst.stall", 64'(dif.stall_req), 64'd0);
        check_eq("rst.inst", 64'(dif.inst_cnt), 64'd0);
        reset = 1'b0;
        tick();

        // Dual commit from empty, consumer ready.
        dif.out_ready = 1'b1;
        dif.bus1 = mk(1'b1, 32'hBFC0_0000, 4'hF, 5'd2, 32'd5, 3'd0, 1'b1);
        dif.bus2 = mk(1'b1, 32'hBFC0_0004, 4'hF, 5'd3, 32'd7, 3'd0, 1'b1);
        check_eq("dual.pre_valid", 64'(dif.wb_valid), 64'd0);
        tick();
        idle();
        check_eq("dual.r0.valid", 64'(dif.wb_valid), 64'd1);
        check_eq("dual.r0.pc", 64'(dif.wb_pc), 64'hBFC0_0000);
        check_eq("dual.r0.wnum", 64'(dif.wb_wnum), 64'd2);
        check_eq("dual.r0.wdata", 64'(dif.wb_wdata), 64'd5);
        check_eq("dual.r0.wen", 64'(dif.wb_wen), 64'hF);
        tick();
        check_eq("dual.r1.pc", 64'(dif.wb_pc), 64'hBFC0_0004);
        check_eq("dual.r1.wnum", 64'(dif.wb_wnum), 64'd3);
        check_eq("dual.r1.wdata", 64'(dif.wb_wdata), 64'd7);
        tick();
        check_eq("dual.empty", 64'(dif.wb_valid), 64'd0);
        check_eq("dual.inst", 64'(dif.inst_cnt), 64'd2);

        // Lone bus2 writing r0: filtered out but still counted.
        dif.bus2 = mk(1'b1, 32'hBFC0_0008, 4'hF, 5'd0, 32'd9, 3'd0, 1'b1);
        tick();
        idle();
        check_eq("r0.valid", 64'(dif.wb_valid), 64'd0);
        check_eq("r0.inst", 64'(dif.inst_cnt), 64'd3);

        // Fill with consumer stalled, then overflow on a dual push at count 7.
        dif.out_ready = 1'b0;
        fill_to_seven();
        check_eq("fill7.overflow", 64'(dif.overflow), 64'd0);
        dif.bus1 = rec(7);
        dif.bus2 = rec(8);
        tick();
        idle();
        check_eq("ovf.flag", 64'(dif.overflow), 64'd1);
        check_eq("ovf.stall", 64'(dif.stall_req), 64'd1);
        expect_head("ovf.head", 0);
        tick();
        expect_head("ovf.hold", 0);
        check_eq("ovf.sticky", 64'(dif.overflow), 64'd1);
        check_eq("ovf.inst", 64'(dif.inst_cnt), 64'd12);
        dif.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_head($sformatf("ovf.drain%0d", k), k);
            tick();
        end
        check_eq("ovf.empty", 64'(dif.wb_valid), 64'd0);
        check_eq("ovf.after", 64'(dif.overflow), 64'd1);

        // Reset clears overflow; dual push at count 7 with a pop fits exactly.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst2.overflow", 64'(dif.overflow), 64'd0);
        tick();
        dif.out_ready = 1'b0;
        fill_to_seven();
        dif.out_ready = 1'b1;
        dif.bus1 = rec(7);
        dif.bus2 = rec(8);
        tick();
        idle();
        check_eq("full.overflow", 64'(dif.overflow), 64'd0);
        check_eq("full.stall", 64'(dif.stall_req), 64'd1);
        for (int k = 1; k < 9; k++) begin
            expect_head($sformatf("full.drain%0d", k), k);
            tick();
        end
        check_eq("full.empty", 64'(dif.wb_valid), 64'd0);
        check_eq("full.inst", 64'(dif.inst_cnt), 64'd9);

        // Branch statistics (records write r0, so nothing is queued).
        dif.bus1 = mk(1'b1, 32'h3000, 4'hF, 5'd0, 32'd0, 3'd1, 1'b1);
        dif.bus2 = mk(1'b1, 32'h3004, 4'hF, 5'd0, 32'd0, 3'd2, 1'b0);
        tick();
        dif.bus1 = mk(1'b1, 32'h3008, 4'hF, 5'd0, 32'd0, 3'd1, 1'b1);
        dif.bus2 = mk(1'b1, 32'h300C, 4'hF, 5'd0, 32'd0, 3'd0, 1'b0);
        tick();
        idle();
        check_eq("br.cnt", 64'(dif.br_cnt), 64'd3);
        check_eq("br.mispred", 64'(dif.mispred_cnt), 64'd1);
        check_eq("br.inst", 64'(dif.inst_cnt), 64'd13);
        check_eq("br.valid", 64'(dif.wb_valid), 64'd0);

        // Reset mid-stream with four records queued.
        dif.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dif.bus1 = rec(2 * i);
            dif.bus2 = rec(2 * i + 1);
            tick();
        end
        idle();
        check_eq("q4.valid", 64'(dif.wb_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst.valid", 64'(dif.wb_valid), 64'd0);
        check_eq("arst.pc", 64'(dif.wb_pc), 64'd0);
        check_eq("arst.inst", 64'(dif.inst_cnt), 64'd0);
        check_eq("arst.br", 64'(dif.br_cnt), 64'd0);
        check_eq("arst.mispred", 64'(dif.mispred_cnt), 64'd0);
        tick();
        reset = 1'b0;
        dif.out_ready = 1'b1;
        tick();
        check_eq("arst.release", 64'(dif.wb_valid), 64'd0);
        tick();
        check_eq("arst.release2", 64'(dif.wb_valid), 64'd0);

        // Twenty single push/pop cycles wrap the pointers; bus2-only on odd ids.
        for (int i = 0; i < 20; i++) begin
            idle();
            if ((i % 2) == 0) dif.bus1 = rec(100 + i);
            else              dif.bus2 = rec(100 + i);
            if (i > 0) expect_head($sformatf("wrap%0d", i - 1), 100 + i - 1);
            tick();
        end
        idle();
        expect_head("wrap19", 119);
        tick();
        check_eq("wrap.empty", 64'(dif.wb_valid), 64'd0);
        check_eq("wrap.inst", 64'(dif.inst_cnt), 64'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/debug_trace_serializer.md
DEBUG_TRACE_SERIALIZER -- requirements
Module: debug_trace_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of two, >= 4).
REQ-002 SHALL have parameter DROP_NO_WRITE, default 1, discarding entries with no effective register write at push.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port debug_bus1, input, debug_bus_t, older committed instruction (valid, pc, wstrb, dest, phy_dest, wdata, br_op, predict_sucess).
REQ-006 SHALL have port debug_bus2, input, debug_bus_t, younger committed instruction in the same cycle.
REQ-007 SHALL have port out_ready, input, 1, trace consumer accepts the head record this cycle.
REQ-008 SHALL have port debug_wb_valid, output, 1, a head record is presented.
REQ-009 SHALL have ports debug_wb_pc (32), debug_wb_rf_wen (4), debug_wb_rf_wnum (5) and debug_wb_rf_wdata (32), all outputs carrying the head record.
REQ-010 SHALL have port stall_req, output, 1, back-pressure to commit.
REQ-011 SHALL have port overflow, output, 1, sticky lost-record flag.
REQ-012 SHALL have ports inst_cnt, br_cnt and mispred_cnt, all outputs, 32 each, performance counters.

Function
REQ-013 SHALL accept a record from a bus whenever its valid=1; debug_bus1 SHALL be ordered ahead of debug_bus2.
REQ-014 SHALL store wen as wstrb, forced to 4'b0 when dest==0.
REQ-015 SHALL, when DROP_NO_WRITE=1, not push a record whose stored wen==0; such records SHALL still be counted.
REQ-016 SHALL push 0, 1 or 2 records per cycle and pop at most 1 per cycle; a lone valid on bus2 SHALL push exactly one record.
REQ-017 SHALL drive debug_wb_valid = (count != 0), with the debug_wb_* outputs taken from the head entry; a pushed record SHALL be visible on the cycle after the push (1-cycle latency).
REQ-018 SHALL pop when debug_wb_valid && out_ready; the debug_wb_* outputs SHALL hold stable while out_ready=0.
REQ-019 SHALL compute capacity = DEPTH - count + pop; records beyond capacity SHALL be dropped in order, with bus2 dropped first, and overflow SHALL set to 1 and stay 1 until reset.
REQ-020 SHALL drive stall_req = ((DEPTH - count) < 2), combinational from the registered count.
REQ-021 SHALL wrap the head and tail pointers modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-022 SHALL increment inst_cnt by the number of valid buses (0..2), before the drop filter and the overflow check.
REQ-023 SHALL increment br_cnt once per valid bus with br_op != 0.
REQ-024 SHALL increment mispred_cnt once per valid bus with br_op != 0 and predict_sucess == 0.
REQ-025 SHALL wrap all counters modulo 2^32 without saturation.
REQ-026 SHALL not react to pipeline flush; committed records are never discarded except on overflow.

Reset
REQ-027 SHALL, on reset, asynchronously clear pointers, count, overflow and all three counters to 0.
REQ-028 SHALL, on reset, hold debug_wb_valid=0 and debug_wb_pc, rf_wen, rf_wnum and rf_wdata at 0.
REQ-029 SHALL not require the FIFO storage itself to reset; outputs are masked to 0 while empty.
REQ-030 SHALL, on reset mid-stream, lose all queued records, with no output pulse on the cycle reset deasserts.

Structure
REQ-031 SHALL take debug_bus_t and a new trace_rec_t {pc, wen, wnum, wdata} from the shared cpu.svh package.
REQ-032 SHALL instantiate one sub-module, trace_fifo: a 2-write, 1-read synchronous FIFO of trace_rec_t, parameterised by DEPTH.
REQ-033 SHALL keep counters, filtering and overflow logic in the top-level module.

Verification
REQ-034 Bench SHALL cover: from empty, bus1 {pc=0xBFC00000, wstrb=F, dest=2, wdata=5} and bus2 {pc=0xBFC00004, wstrb=F, dest=3, wdata=7} in one cycle, out_ready=1 -> next cycle 0xBFC00000/wnum 2, following cycle 0xBFC00004/wnum 3, then valid=0.
REQ-035 Bench SHALL cover: bus2-only valid, dest=0, wstrb=F, DROP_NO_WRITE=1 -> nothing pushed, inst_cnt+1.
REQ-036 Bench SHALL cover: DEPTH=8, out_ready=0, dual pushes -> stall_req=1 once count=7; a dual push at count=7 -> bus1 stored, bus2 dropped, overflow=1.
REQ-037 Bench SHALL cover: count=7, dual push with simultaneous pop -> both accepted, count=8, overflow stays 0.
REQ-038 Bench SHALL cover: 3 branches with one predict_sucess=0 -> br_cnt=3, mispred_cnt=1; reset asserted with 4 queued -> valid=0 and counters=0 immediately.
REQ-039 Bench SHALL cover: 20 single pushes/pops -> pointer wrap with order preserved.
